// File: rtl/snake_pkg.sv
// Shared game types and the step sequencer state encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    GAME  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_mode;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DIR,
    MOVE,
    COLL,
    GEN,
    DONE,
    ERROR
  } step_state_t;

  localparam int unsigned STEP_TIMEOUT_DEFAULT = 750000;

endpackage

// File: rtl/step_timer.sv
// Remote-direction timeout counter; present only in builds with STEP_TIMEOUT_EN.
module step_timer
  import snake_pkg::*;
#(
  parameter int unsigned LIMIT = STEP_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT - 1));

  // Holds at the limit so the count never wraps while still enabled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_step_seq.sv
// Game step sequencer: tick -> direction -> move -> collision -> point gen -> refreshed.
// Define STEP_TIMEOUT_EN to enable the remote-direction timeout and ERROR state.
module game_step_seq
  import snake_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = STEP_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  game_mode         mode,
  input  logic             tick,
  input  logic             rcvdir,
  input  logic             move_done,
  input  logic             coll_done,
  input  logic             gen_done,
  output logic             move_start,
  output logic             coll_start,
  output logic             gen_start,
  output logic             refreshed,
  output logic             con_error,
  output logic             overrun,
  output logic [CNT_W-1:0] step_cnt
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  step_state_t state, state_nxt;
  game_mode    mode_q;
  logic        dir_flag;
  logic        dir_go;
  logic        mode_entry;
  logic        timeout;
  logic        move_nxt, coll_nxt, gen_nxt, ref_nxt;

  assign mode_entry = (mode == GAME) && (mode_q != GAME);
  // A direction arriving in the WAIT_DIR cycle itself is taken without a flag round-trip.
  assign dir_go     = dir_flag || rcvdir;

`ifdef STEP_TIMEOUT_EN
  step_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT_DIR),
    .enable (state == WAIT_DIR),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst || mode_entry) begin
      con_error <= 1'b0;
    end else if (state == ERROR) begin
      con_error <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign con_error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    move_nxt  = 1'b0;
    coll_nxt  = 1'b0;
    gen_nxt   = 1'b0;
    ref_nxt   = 1'b0;
    if (mode != GAME) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (tick) state_nxt = WAIT_DIR;
        WAIT_DIR: begin
          if (dir_go) begin
            state_nxt = MOVE;
            move_nxt  = 1'b1;
          end else if (timeout) begin
            state_nxt = ERROR;
          end
        end
        MOVE: begin
          if (move_done) begin
            state_nxt = COLL;
            coll_nxt  = 1'b1;
          end
        end
        COLL: begin
          if (coll_done) begin
            state_nxt = GEN;
            gen_nxt   = 1'b1;
          end
        end
        GEN: begin
          if (gen_done) begin
            state_nxt = DONE;
            ref_nxt   = 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (mode != GAME)) begin
      dir_flag <= 1'b0;
    end else if (rcvdir) begin
      dir_flag <= 1'b1;
    end else if (move_start) begin
      dir_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= MENU;
      move_start <= 1'b0;
      coll_start <= 1'b0;
      gen_start  <= 1'b0;
      refreshed  <= 1'b0;
      overrun    <= 1'b0;
      step_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      mode_q     <= mode;
      move_start <= move_nxt;
      coll_start <= coll_nxt;
      gen_start  <= gen_nxt;
      refreshed  <= ref_nxt;
      if (mode_entry) begin
        overrun  <= 1'b0;
        step_cnt <= '0;
      end else begin
        if (ref_nxt) step_cnt <= step_cnt + 1'b1;
        if (tick && (state != IDLE)) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_step_seq.sv
// Scoreboard bench for game_step_seq: planned steps push expected strobes, a monitor pops them.
module tb_game_step_seq;
  import snake_pkg::*;

  localparam int unsigned TO   = 20;
  localparam int unsigned CW   = 6;
  localparam int          MASK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  game_mode      mode;
  logic          tick, rcvdir, move_done, coll_done, gen_done;
  logic          move_start, coll_start, gen_start, refreshed;
  logic          con_error, overrun;
  logic [CW-1:0] step_cnt;

  game_step_seq #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .tick      (tick),
    .rcvdir    (rcvdir),
    .move_done (move_done),
    .coll_done (coll_done),
    .gen_done  (gen_done),
    .move_start(move_start),
    .coll_start(coll_start),
    .gen_start (gen_start),
    .refreshed (refreshed),
    .con_error (con_error),
    .overrun   (overrun),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int kind;   // 0 move_start, 1 coll_start, 2 gen_start, 3 refreshed
    int at;
    int cnt;
    int ov;
  } exp_t;

  exp_t sb[$];

  // Reference view of the block: completed-step count, sticky overrun, pending direction.
  int cnt_m  = 0;
  bit ov_m   = 1'b0;
  bit flag_m = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int rr(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic push(input int kind, input int at, input int cnt, input int ov);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    e.cnt  = cnt;
    e.ov   = ov;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int   s, kind;
    exp_t e;
    s = int'(move_start) + int'(coll_start) + int'(gen_start) + int'(refreshed);
    if (s != 0) begin
      chk("one_strobe", s, 1);
      kind = move_start ? 0 : coll_start ? 1 : gen_start ? 2 : 3;
      if (sb.size() == 0) begin
        chk("unexpected_strobe_kind", kind, -1);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_cycle", cyc, e.at);
        if (kind == 3 && e.kind == 3) begin
          chk("step_cnt", int'(step_cnt), e.cnt);
          chk("overrun", int'(overrun), e.ov);
          chk("con_error", int'(con_error), 0);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
    tick      = 1'b0;
    rcvdir    = 1'b0;
    move_done = 1'b0;
    coll_done = 1'b0;
    gen_done  = 1'b0;
  endtask

  // One planned step. dsel: 0 direction before/at tick, 1 direction doff cycles into WAIT_DIR.
  // xsel/ksel: 0 none, 1 at move_start, 2 random in step. abort: 0 none, 1 MENU in COLL, 2 rst.
  task automatic run_step(input int gap, input int dsel, input int doff,
                          input int d1, input int d2, input int d3,
                          input int xsel, input int ksel, input int abort_kind);
    int n, k, ms, md, cs, cd, gs, gd, rf, xt, kc, spm, spc, spg, a, last;
    n = cyc + 1 + gap;
    k = -1;
    if (flag_m) begin
      ms = n + 2;
    end else if (dsel == 0) begin
      k  = n - doff;
      if (k < cyc + 1) k = cyc + 1;
      ms = n + 2;
    end else begin
      k  = n + 1 + doff;
      ms = k + 1;
    end
    md = ms + d1;  cs = md + 1;
    cd = cs + d2;  gs = cd + 1;
    gd = gs + d3;  rf = gd + 1;
    xt  = (xsel == 1) ? ms : (xsel == 2) ? rr(n + 1, rf - 1) : -1;
    kc  = (ksel == 1) ? ms : (ksel == 2) ? rr(ms, rf) : -1;
    spc = rr(n, cs - 1);
    spg = rr(n, gs - 1);
    spm = rr(cs, rf);
    a   = (abort_kind == 1) ? rr(cs, cd) : (abort_kind == 2) ? rr(n + 1, rf - 1) : rf + 1;
    last = (abort_kind != 0) ? a : rf;

    if (ms <= a) push(0, ms, 0, 0);
    if (cs <= a) push(1, cs, 0, 0);
    if (gs <= a) push(2, gs, 0, 0);
    if (rf <= a) push(3, rf, (cnt_m + 1) & MASK, int'(ov_m || (xt >= 0)));

    for (int c = cyc + 1; c <= last; c++) begin
      next_cyc();
      if (c < a) begin
        tick      = (c == n) || (c == xt);
        rcvdir    = (c == k) || (c == kc);
        move_done = (c == md) || (c == spm);
        coll_done = (c == cd) || (c == spc);
        gen_done  = (c == gd) || (c == spg);
      end else if (abort_kind == 1) begin
        mode = MENU;
      end else begin
        rst = 1'b1;
      end
    end

    if (abort_kind != 0) begin
      repeat (rr(2, 4)) next_cyc();
      mode = GAME;
      rst  = 1'b0;
      cnt_m  = 0;
      ov_m   = 1'b0;
      flag_m = 1'b0;
      next_cyc();
      next_cyc();
      chk("abort_step_cnt", int'(step_cnt), 0);
      chk("abort_overrun", int'(overrun), 0);
    end else begin
      cnt_m  = (cnt_m + 1) & MASK;
      ov_m   = ov_m || (xt >= 0);
      flag_m = (kc >= 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cycle %0d exceeded time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst       = 1'b1;
    mode      = MENU;
    tick      = 1'b0;
    rcvdir    = 1'b0;
    move_done = 1'b0;
    coll_done = 1'b0;
    gen_done  = 1'b0;
    repeat (3) next_cyc();
    chk("rst_move_start", int'(move_start), 0);
    chk("rst_coll_start", int'(coll_start), 0);
    chk("rst_gen_start", int'(gen_start), 0);
    chk("rst_refreshed", int'(refreshed), 0);
    chk("rst_con_error", int'(con_error), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_step_cnt", int'(step_cnt), 0);
    rst  = 1'b0;
    mode = GAME;
    next_cyc();

    // Direction 3 cycles before tick, each done one cycle after its start.
    run_step(4, 0, 3, 1, 1, 1, 0, 0, 0);
    chk("first_step_cnt", int'(step_cnt), cnt_m);

    // Second tick during MOVE.
    run_step(2, 1, 0, 1, 1, 1, 1, 0, 0);
    chk("overrun_sticky", int'(overrun), 1);

    // Direction coincident with move_start carries into the next step.
    run_step(1, 1, 2, 2, 1, 1, 0, 1, 0);
    run_step(3, 1, 5, 1, 1, 1, 0, 0, 0);

`ifdef STEP_TIMEOUT_EN
    next_cyc();
    tick = 1'b1;
    t0   = cyc;
    repeat (21) next_cyc();
    chk("con_error_before_timeout", int'(con_error), 0);
    next_cyc();
    chk("con_error_at_timeout", int'(con_error), 1);
    repeat (3) next_cyc();
    chk("con_error_sticky", int'(con_error), 1);
    mode = MENU;
    next_cyc();
    next_cyc();
    mode = GAME;
    next_cyc();
    next_cyc();
    chk("con_error_cleared", int'(con_error), 0);
    chk("timeout_t0_used", cyc - t0, 29);
    cnt_m  = 0;
    ov_m   = 1'b0;
    flag_m = 1'b0;
    chk("reentry_step_cnt", int'(step_cnt), 0);
`else
    // Direction 30 cycles into WAIT_DIR still starts the move.
    run_step(1, 1, 30, 1, 1, 1, 0, 0, 0);
    chk("con_error_tied", int'(con_error), 0);
    t0 = cyc;
`endif

    // Mode leaves GAME during COLL.
    run_step(1, 1, 1, 1, 3, 1, 0, 0, 1);

    // Long unaborted run to carry step_cnt through its wrap.
    repeat (70) run_step(rr(0, 3), rr(0, 1), rr(0, 2), rr(1, 3), rr(1, 3), rr(1, 3),
                         rr(0, 2), rr(0, 2), 0);

    // Mixed run with occasional mode aborts and resets.
    repeat (60) begin
      int ab;
      ab = rr(0, 7);
      ab = (ab == 6) ? 1 : (ab == 7) ? 2 : 0;
      run_step(rr(0, 3), rr(0, 1), rr(0, 4), rr(1, 3), rr(1, 3), rr(1, 3),
               rr(0, 2), rr(0, 2), ab);
    end

    repeat (5) next_cyc();
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_step_seq.md
GAME_STEP_SEQ -- requirements
Module: game_step_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 750000, the number of clk cycles to wait for the remote direction before flagging an error (10 ms at 75 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, the width of step_cnt.
REQ-003 clk  in  1  system clock, 75 MHz; the only clock in the block.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 mode  in  game_mode  current game mode; the block sequences only in GAME.
REQ-006 tick  in  1  one-cycle step request from the clock divider.
REQ-007 rcvdir  in  1  one-cycle pulse: remote direction received.
REQ-008 move_done, coll_done, gen_done  in  1 each  one-cycle completion pulses from the move, collision and point-generation stages.
REQ-009 move_start, coll_start, gen_start  out  1 each  one-cycle stage start strobes.
REQ-010 refreshed  out  1  one-cycle pulse: step complete, map stable.
REQ-011 con_error  out  1  sticky remote-timeout flag.
REQ-012 overrun  out  1  sticky flag: a tick arrived while a step was in progress.
REQ-013 step_cnt  out  CNT_W  count of completed steps.

Function
REQ-014 SHALL implement the states IDLE, WAIT_DIR, MOVE, COLL, GEN, DONE and ERROR.
REQ-015 IDLE: when mode==GAME and tick is high in cycle N, SHALL be in WAIT_DIR at N+1; otherwise SHALL stay in IDLE.
REQ-016 SHALL keep a dir_flag that is set by rcvdir in any state and cleared when move_start is issued; if set and clear occur in the same cycle, set SHALL win.
REQ-017 WAIT_DIR with dir_flag set SHALL assert move_start for exactly one cycle and go to MOVE.
REQ-018 MOVE, COLL and GEN SHALL each wait for their done pulse, then assert the next strobe (coll_start, gen_start, or refreshed) in the following cycle.
REQ-019 DONE SHALL pulse refreshed, increment step_cnt modulo 2^CNT_W (0xFFFF wraps to 0x0000), and return to IDLE.
REQ-020 Minimum latency SHALL be tick at N with dir_flag set, done pulses returned one cycle after each start, and refreshed at N+8.
REQ-021 At most one strobe output SHALL be high in any cycle.
REQ-022 A tick in any state other than IDLE SHALL be dropped and SHALL set overrun; the step in progress SHALL continue.
REQ-023 A done pulse that arrives in a state not waiting for it SHALL be ignored.
REQ-024 When mode!=GAME in any state, the block SHALL go to IDLE in the next cycle, with strobes low and dir_flag cleared.
REQ-025 On a transition of mode into GAME, step_cnt, overrun and con_error SHALL clear.
REQ-026 ERROR: con_error SHALL stay high; the block SHALL leave ERROR only through rst or mode!=GAME.

Reset
REQ-027 On rst, the state SHALL be IDLE and all outputs 0, with dir_flag, the timeout counter and step_cnt cleared.
REQ-028 A rst asserted mid-step SHALL abort the step with no further strobes issued.

Configuration
REQ-029 With STEP_TIMEOUT_EN defined, a counter SHALL run in WAIT_DIR and reset on leaving it; when it reaches TIMEOUT_CYCLES-1 without dir_flag set, the block SHALL go to ERROR and set con_error in the next cycle.
REQ-030 Without STEP_TIMEOUT_EN, WAIT_DIR SHALL wait indefinitely, con_error SHALL be tied to 0, ERROR SHALL be unreachable, and no counter logic SHALL be present.

Structure
REQ-031 snake_pkg SHALL hold the step_state_t enum and STEP_TIMEOUT_DEFAULT; game_mode SHALL remain in snake_pkg.
REQ-032 The timeout counter SHALL be the single sub-module step_timer (clear and enable inputs, expired output), instantiated only under STEP_TIMEOUT_EN.

Verification
REQ-033 Case: mode=GAME, rcvdir at cycle 2, tick at 5, each done returned 1 cycle after its start -> move_start@7, coll_start@9, gen_start@11, refreshed@13, step_cnt=1.
REQ-034 Case: tick with no rcvdir, TIMEOUT_CYCLES=20, STEP_TIMEOUT_EN defined -> con_error=1 at tick+22 and no move_start; with the macro undefined, a later rcvdir -> move_start in the next cycle.
REQ-035 Case: a second tick during MOVE -> overrun=1 and exactly one refreshed for the step.
REQ-036 Case: mode switched to MENU during COLL -> IDLE next cycle and no gen_start; a subsequent return to GAME -> step_cnt=0.
REQ-037 Case: step_cnt preloaded through 0xFFFF completed steps plus one more -> step_cnt=0x0000.
REQ-038 Case: rcvdir in the same cycle as move_start -> dir_flag=1 and the next tick proceeds to move_start without waiting.
